mov_demux_bus: RTL and testbench

- Write-side counterpart of the 16-source move mux bus: takes one move word plus a 4-bit destination index and delivers it to one of 16 destination lanes.
- Destinations share a broadcast data bus; each has its own write-enable and acknowledge.
- Registered, single-outstanding move engine with valid/ready intake, per-lane ack wait, ack timeout and sticky error.
- Sits between the PIM controller's move issue stage and the 16 crossbar/register destinations.

---
 rtl/mov_pkg.sv | 21 ++
 rtl/mov_ack_timer.sv | 29 ++
 rtl/mov_demux_bus.sv | 135 +++++++++++++
 tb/tb_mov_demux_bus.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mov_pkg.sv
// Shared lane/selector sizing, write-FSM state type and one-hot decode for the move demux bus.
package mov_pkg;

  localparam int NUM_MOV_LANES = 16;
  localparam int MOV_SEL_W     = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } mov_wr_state_e;

  typedef logic [NUM_MOV_LANES-1:0] mov_lane_mask_t;

  function automatic mov_lane_mask_t onehot16(input logic [MOV_SEL_W-1:0] sel);
    mov_lane_mask_t m;
    m      = '0;
    m[sel] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/mov_ack_timer.sv
// Ack wait timer: 8-bit counter cleared on load, stepped on inc; o_expire flags the last allowed WRITE cycle.
// Latency: o_expire is a pure compare of the registered count; no backpressure.
module mov_ack_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_inc,
  output logic o_expire
);

  localparam logic [7:0] LP_LAST = 8'(ACK_TIMEOUT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expire = (r_cnt == LP_LAST);

endmodule

// File: rtl/mov_demux_bus.sv
// Move demux: one word to one of 16 lanes (all 16 with MOV_BCAST_EN), single outstanding, ack wait + timeout.
// Latency: out_we one cycle after accept, done >= 2 cycles; in_ready low for the whole WRITE phase.
module mov_demux_bus
  import mov_pkg::*;
#(
  parameter int bus_size    = 10,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [bus_size-1:0]      in_data,
  input  logic [MOV_SEL_W-1:0]     in_sel,
  input  logic                     in_bcast,
  output logic [bus_size-1:0]      out_data,
  output logic [NUM_MOV_LANES-1:0] out_we,
  input  logic [NUM_MOV_LANES-1:0] dest_ack,
  output logic                     done,
  output logic                     err_timeout,
  output logic                     err_sticky,
  input  logic                     err_clr
);

  mov_wr_state_e  r_state, w_state_nxt;
  logic [bus_size-1:0] r_data, w_data_nxt;
  mov_lane_mask_t r_target, w_target_nxt;
  mov_lane_mask_t r_ack_mask, w_ack_mask_nxt;
  mov_lane_mask_t r_we, w_we_nxt;
  logic r_done, w_done_nxt;
  logic r_err_to, w_err_to_nxt;
  logic r_sticky, w_sticky_nxt;

  mov_lane_mask_t w_target_in;
  mov_lane_mask_t w_ack_acc;
  logic w_accept;
  logic w_complete;
  logic w_expire;
  logic w_inc;

`ifdef MOV_BCAST_EN
  assign w_target_in = in_bcast ? {NUM_MOV_LANES{1'b1}} : onehot16(in_sel);
`else
  logic w_unused_bcast;
  assign w_unused_bcast = in_bcast;
  assign w_target_in    = onehot16(in_sel);
`endif

  assign in_ready   = (r_state == IDLE);
  assign w_accept   = in_valid & in_ready;
  // Only target lanes count; acks on other lanes never reach the mask.
  assign w_ack_acc  = r_ack_mask | (dest_ack & r_target);
  assign w_complete = (w_ack_acc == r_target);

  mov_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_inc   (w_inc),
    .o_expire(w_expire)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_data_nxt     = r_data;
    w_target_nxt   = r_target;
    w_ack_mask_nxt = r_ack_mask;
    w_we_nxt       = r_we;
    w_done_nxt     = 1'b0;
    w_err_to_nxt   = 1'b0;
    w_inc          = 1'b0;
    w_sticky_nxt   = err_clr ? 1'b0 : r_sticky;

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_data_nxt     = in_data;
          w_target_nxt   = w_target_in;
          w_ack_mask_nxt = '0;
          w_we_nxt       = w_target_in;
          w_state_nxt    = WRITE;
        end
      end
      WRITE: begin
        // An ack landing on the last timeout cycle still completes the move.
        if (w_complete) begin
          w_we_nxt    = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_expire) begin
          w_we_nxt     = '0;
          w_err_to_nxt = 1'b1;
          w_sticky_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end else begin
          w_inc          = 1'b1;
          w_ack_mask_nxt = w_ack_acc;
          w_we_nxt       = r_target & ~w_ack_acc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_target   <= '0;
      r_ack_mask <= '0;
      r_we       <= '0;
      r_done     <= 1'b0;
      r_err_to   <= 1'b0;
      r_sticky   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_data     <= w_data_nxt;
      r_target   <= w_target_nxt;
      r_ack_mask <= w_ack_mask_nxt;
      r_we       <= w_we_nxt;
      r_done     <= w_done_nxt;
      r_err_to   <= w_err_to_nxt;
      r_sticky   <= w_sticky_nxt;
    end
  end

  assign out_data    = r_data;
  assign out_we      = r_we;
  assign done        = r_done;
  assign err_timeout = r_err_to;
  assign err_sticky  = r_sticky;

endmodule

// File: tb/tb_mov_demux_bus.sv
// Randomized bench for mov_demux_bus against a per-move timing model (ack delay -> done or timeout).
`timescale 1ns/1ps
module tb_mov_demux_bus;

  localparam int BW = 10;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [BW-1:0]   in_data = '0;
  logic [3:0]      in_sel = '0;
  logic            in_bcast = 1'b0;
  logic [BW-1:0]   out_data;
  logic [15:0]     out_we;
  logic [15:0]     dest_ack = '0;
  logic            done;
  logic            err_timeout;
  logic            err_sticky;
  logic            err_clr = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  // Model state: what err_sticky and out_data should hold right now.
  logic          m_sticky = 1'b0;
  logic [BW-1:0] m_data = '0;

  always #5 clk = ~clk;

  mov_demux_bus #(
    .bus_size   (BW),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_bcast   (in_bcast),
    .out_data   (out_data),
    .out_we     (out_we),
    .dest_ack   (dest_ack),
    .done       (done),
    .err_timeout(err_timeout),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] we, input logic dn,
                         input logic et, input logic rdy);
    chk({tag, ".we"},     32'(out_we),      32'(we));
    chk({tag, ".done"},   32'(done),        32'(dn));
    chk({tag, ".err"},    32'(err_timeout), 32'(et));
    chk({tag, ".rdy"},    32'(in_ready),    32'(rdy));
    chk({tag, ".sticky"}, 32'(err_sticky),  32'(m_sticky));
    chk({tag, ".data"},   32'(out_data),    32'(m_data));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sticky flag after the coming edge: a timeout set beats a same-cycle clear.
  task automatic edge_sticky(input bit set);
    if (set) m_sticky = 1'b1;
    else if (err_clr) m_sticky = 1'b0;
  endtask

  // One move; target acks in WRITE cycle d (d >= TO means never). Call in an IDLE cycle.
  task automatic do_move(input logic [BW-1:0] data, input logic [3:0] sel, input int d,
                         input bit rnd_clr, input bit bc);
    logic [15:0] tgt;
    int          last;
    bit          to;
    tgt  = bc ? 16'hFFFF : (16'h0001 << sel);
    to   = (d > TO - 1);
    last = to ? TO - 1 : d;
    chk("acc.rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_sel   = sel;
`ifdef MOV_BCAST_EN
    in_bcast = bc;
`else
    in_bcast = 1'($urandom);
`endif
    dest_ack = 16'($urandom);
    err_clr  = rnd_clr ? 1'($urandom) : 1'b0;
    edge_sticky(1'b0);
    step();
    m_data   = data;
    in_valid = 1'b0;
    for (int k = 0; k <= last; k++) begin
      chk_out("wr", tgt, 1'b0, 1'b0, 1'b0);
      in_data  = BW'($urandom);
      in_sel   = 4'($urandom);
      dest_ack = (16'($urandom) & ~tgt) | ((k == d) ? tgt : 16'h0000);
      err_clr  = rnd_clr ? 1'($urandom) : 1'b0;
      edge_sticky(k == last && to);
      step();
    end
    dest_ack = 16'($urandom);
    err_clr  = 1'b0;
    chk_out("end", 16'h0000, !to, to, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      dest_ack = 16'($urandom);
      err_clr  = 1'($urandom);
      edge_sticky(1'b0);
      step();
      err_clr = 1'b0;
      chk_out("idle", 16'h0000, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    // Reset values
    rst_n = 1'b0;
    step();
    step();
    chk_out("reset", 16'h0000, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;

    // Single move, immediate ack
    do_move(10'h2A5, 4'd7, 0, 1'b0, 1'b0);
    // Wrong-lane acks only: full timeout
    do_move(10'h155, 4'd3, 99, 1'b0, 1'b0);
    err_clr = 1'b1;
    edge_sticky(1'b0);
    step();
    err_clr = 1'b0;
    chk("clr.sticky", 32'(err_sticky), 32'd0);
    // Ack on the final allowed cycle wins over timeout
    do_move(10'h0F0, 4'd3, TO - 1, 1'b0, 1'b0);
    // Timeout again so the reset below must clear sticky
    do_move(10'h001, 4'd11, 20, 1'b0, 1'b0);

    // Reset in the middle of a move
    in_valid = 1'b1;
    in_sel   = 4'd15;
    in_data  = 10'h3FF;
    dest_ack = 16'h0000;
    step();
    in_valid = 1'b0;
    m_data   = 10'h3FF;
    chk_out("rstmid.wr", 16'h8000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    m_sticky = 1'b0;
    m_data   = '0;
    chk_out("rstmid", 16'h0000, 1'b0, 1'b0, 1'b1);

    // Back-to-back with immediate acks
    do_move(10'h011, 4'd0, 0, 1'b0, 1'b0);
    do_move(10'h022, 4'd15, 0, 1'b0, 1'b0);
    do_move(10'h033, 4'd9, 0, 1'b0, 1'b0);

`ifdef MOV_BCAST_EN
    in_valid = 1'b1;
    in_bcast = 1'b1;
    in_sel   = 4'd5;
    in_data  = 10'h2C3;
    dest_ack = 16'h0000;
    step();
    in_valid = 1'b0;
    in_bcast = 1'b0;
    m_data   = 10'h2C3;
    chk_out("bc0", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    dest_ack = 16'h00FF;
    step();
    chk_out("bc1", 16'hFF00, 1'b0, 1'b0, 1'b0);
    dest_ack = 16'h0000;
    step();
    chk_out("bc2", 16'hFF00, 1'b0, 1'b0, 1'b0);
    dest_ack = 16'hFF00;
    step();
    chk_out("bcE", 16'h0000, 1'b1, 1'b0, 1'b1);
`endif

    // Random moves, delays, gaps and clears
    for (int i = 0; i < 60; i++) begin
      do_move(BW'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 20), 1'b1, 1'b0);
      idle($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
